ex_muldiv: RTL and testbench

Iterative RV32M/RV64M multiply-divide execute unit for the EX stage, parametrised in XLEN. It sits beside the single-cycle ALU and takes the same operands, destination and write-enable from ID/EX. While an operation runs it holds the pipeline with a stall request, then presents one result with the same write-back fields (wd/wreg/wdata) as the ALU path. It handles signed and unsigned forms, RISC-V divide-by-zero and overflow semantics, and pipeline flush.

---
 rtl/ex_muldiv_pkg.sv | 31 +++
 rtl/ex_muldiv_iter.sv | 30 +++
 rtl/ex_muldiv.sv | 131 +++++++++++++
 tb/tb_ex_muldiv.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the M-extension execute unit.
// Holds the funct3 op encodings, the FSM state type and operand-sign helpers.
package ex_muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

   // rs1 is signed for every form except the fully unsigned ones
   function automatic logic a_is_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic b_is_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// One-bit-per-cycle step: shift-add multiply or restoring divide on a
// shared 2*XLEN accumulator ({hi, lo}).
module muldiv_iter #(
   parameter int XLEN = 32
) (
   input  logic              is_div,
   input  logic [XLEN-1:0]   opnd,
   input  logic [2*XLEN-1:0] acc,
   output logic [2*XLEN-1:0] acc_nxt
);

   logic [XLEN:0] sum;
   logic [XLEN:0] rem_sh;
   logic [XLEN:0] trial;

   // Multiply: lo holds the remaining multiplier bits, hi the partial product.
   // Divide: hi holds the partial remainder, lo shifts dividend out / quotient in.
   always_comb begin
      sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
      rem_sh = acc[2*XLEN-1:XLEN-1];
      trial  = rem_sh - {1'b0, opnd};
      if (!is_div)
         acc_nxt = {sum, acc[XLEN-1:1]};
      else if (!trial[XLEN])
         acc_nxt = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
         acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
   end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit beside the EX-stage ALU: stalls the pipe
// while computing, then emits one write-back result.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  start_i,
   input  logic [2:0]            op_i,
   input  logic [XLEN-1:0]       a_i,
   input  logic [XLEN-1:0]       b_i,
   input  logic [REG_ADDR_W-1:0] wd_i,
   input  logic                  wreg_i,
   output logic                  stall_req_o,
   output logic                  valid_o,
   output logic [XLEN-1:0]       wdata_o,
   output logic [REG_ADDR_W-1:0] wd_o,
   output logic                  wreg_o,
   output logic                  busy_o
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
   localparam logic [CW-1:0]   LAST = CW'(XLEN-1);

   md_state_e         state;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc, acc_nxt;
   logic [XLEN-1:0]   opnd;
   logic [2:0]        op_q;
   logic              neg_res, neg_rem, wreg_q;

   logic              a_neg, b_neg, div_zero, ovf, accept;
   logic [XLEN-1:0]   a_mag, b_mag, spec_res, quo, rem, fix_res;
   logic [2*XLEN-1:0] prod;

   always_comb begin
      a_neg    = a_is_signed(op_i) & a_i[XLEN-1];
      b_neg    = b_is_signed(op_i) & b_i[XLEN-1];
      a_mag    = a_neg ? -a_i : a_i;
      b_mag    = b_neg ? -b_i : b_i;
      div_zero = op_i[2] && (b_i == '0);
      ovf      = ((op_i == OP_DIV) || (op_i == OP_REM)) && (a_i == SMIN) && (b_i == ONES);
      // op[1] distinguishes REM* from DIV*
      if (div_zero) spec_res = op_i[1] ? a_i : ONES;
      else          spec_res = op_i[1] ? '0  : a_i;
   end

   always_comb begin
      prod = neg_res ? -acc : acc;
      quo  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      case (op_q)
         OP_MUL:                        fix_res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               fix_res = quo;
         default:                       fix_res = rem;
      endcase
   end

   muldiv_iter #(.XLEN(XLEN)) u_iter (
      .is_div  (op_q[2]),
      .opnd    (opnd),
      .acc     (acc),
      .acc_nxt (acc_nxt)
   );

   assign accept      = (state == ST_IDLE) && start_i && !flush_i;
   assign stall_req_o = accept || (state == ST_CALC) || (state == ST_FIX);
   assign busy_o      = (state != ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         acc     <= '0;
         opnd    <= '0;
         op_q    <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         wreg_q  <= 1'b0;
         valid_o <= 1'b0;
         wdata_o <= '0;
         wd_o    <= '0;
         wreg_o  <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         wreg_o  <= 1'b0;
         case (state)
            ST_IDLE: if (accept) begin
               op_q    <= op_i;
               wd_o    <= wd_i;
               wreg_q  <= wreg_i;
               neg_res <= a_neg ^ b_neg;
               neg_rem <= a_neg;
               cnt     <= '0;
               if (div_zero || ovf) begin
                  wdata_o <= spec_res;
                  valid_o <= 1'b1;
                  wreg_o  <= wreg_i;
                  state   <= ST_DONE;
               end else begin
                  acc   <= op_i[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                  opnd  <= op_i[2] ? b_mag : a_mag;
                  state <= ST_CALC;
               end
            end
            ST_CALC: if (flush_i) state <= ST_IDLE;
            else begin
               acc <= acc_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= ST_FIX;
            end
            ST_FIX: if (flush_i) state <= ST_IDLE;
            else begin
               wdata_o <= fix_res;
               valid_o <= 1'b1;
               wreg_o  <= wreg_q;
               state   <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomised self-checking bench for ex_muldiv against a plain-arithmetic
// reference of the RV32M result rules, plus latency, flush and reset checks.
module tb_ex_muldiv;

   localparam int XLEN = 32;
   localparam int RW   = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush_i, start_i, wreg_i;
   logic [2:0]      op_i;
   logic [XLEN-1:0] a_i, b_i;
   logic [RW-1:0]   wd_i;
   logic            stall_req_o, valid_o, wreg_o, busy_o;
   logic [XLEN-1:0] wdata_o;
   logic [RW-1:0]   wd_o;

   int n_chk = 0;
   int n_err = 0;

   ex_muldiv #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .start_i(start_i), .op_i(op_i),
      .a_i(a_i), .b_i(b_i), .wd_i(wd_i), .wreg_i(wreg_i),
      .stall_req_o(stall_req_o), .valid_o(valid_o), .wdata_o(wdata_o),
      .wd_o(wd_o), .wreg_o(wreg_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint          sa, sb, p;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin up = ua * ub; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            p = sa % sb; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Issue one op from the current cycle (T), follow it to its valid pulse.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit poke, input string tag);
      logic [31:0]   exp;
      logic [RW-1:0] wd;
      logic          wr;
      int            exp_lat, n;
      bit            stall_ok;
      wd  = RW'($urandom);
      wr  = 1'($urandom);
      exp = ref_md(op, a, b);
      exp_lat = ((op[2] && b == 0) ||
                 ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
                ? 1 : XLEN + 2;
      op_i = op; a_i = a; b_i = b; wd_i = wd; wreg_i = wr; start_i = 1'b1;
      #1;
      chk({tag, " stall@T"}, 64'(stall_req_o), 64'd1);
      @(posedge clk); #1;
      start_i = 1'b0;
      op_i = 3'($urandom); a_i = $urandom; b_i = $urandom; wd_i = RW'($urandom); wreg_i = 1'($urandom);
      n = 1; stall_ok = 1'b1;
      while (!valid_o && n < 60) begin
         if (!stall_req_o || !busy_o) stall_ok = 1'b0;
         start_i = (poke && n == 5);
         @(posedge clk); #1;
         n++;
      end
      start_i = 1'b0;
      chk({tag, " latency"}, 64'(n), 64'(exp_lat));
      chk({tag, " wdata"}, 64'(wdata_o), 64'(exp));
      chk({tag, " wd"}, 64'(wd_o), 64'(wd));
      chk({tag, " wreg"}, 64'(wreg_o), 64'(wr));
      chk({tag, " stall@done"}, 64'(stall_req_o), 64'd0);
      if (exp_lat > 1) chk({tag, " stall-hold"}, 64'(stall_ok), 64'd1);
      @(posedge clk); #1;
      chk({tag, " pulse"}, {62'd0, valid_o, busy_o}, 64'd0);
   endtask

   initial begin
      rst = 1'b1; flush_i = 1'b0; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
      wd_i = '0; wreg_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset outs", {58'd0, stall_req_o, valid_o, wreg_o, busy_o, 2'b00}, 64'd0);
      chk("reset wdata", 64'(wdata_o), 64'd0);
      chk("reset wd", 64'(wd_o), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, "mul");
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulh");
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhu");
      run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "mulhsu");
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, "rem");
      run_op(3'd5, 32'd100, 32'd7, 1'b1, "divu-poke");
      run_op(3'd7, 32'd100, 32'd7, 1'b0, "remu");
      run_op(3'd5, 32'd5, 32'd0, 1'b0, "divu0");
      run_op(3'd6, 32'd5, 32'd0, 1'b0, "rem0");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div-ovf");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem-ovf");

      // flush beats start while idle
      op_i = 3'd0; a_i = 32'd9; b_i = 32'd9; start_i = 1'b1; flush_i = 1'b1;
      #1;
      chk("idle-flush stall", 64'(stall_req_o), 64'd0);
      @(posedge clk); #1;
      chk("idle-flush busy", 64'(busy_o), 64'd0);
      start_i = 1'b0; flush_i = 1'b0;

      // flush mid-CALC at T+10, restart at T+11
      op_i = 3'd5; a_i = 32'hDEAD_BEEF; b_i = 32'd3; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush_i = 1'b1; start_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0; start_i = 1'b0;
      chk("flush idle", {62'd0, busy_o, valid_o}, 64'd0);
      chk("flush stall", 64'(stall_req_o), 64'd0);
      run_op(3'd7, 32'hDEAD_BEEF, 32'd10, 1'b0, "after-flush");

      // asynchronous reset mid-CALC
      op_i = 3'd1; a_i = 32'h1234_5678; b_i = 32'h9ABC_DEF0; wd_i = 5'd31; wreg_i = 1'b1;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst-mid outs", {58'd0, stall_req_o, valid_o, wreg_o, busy_o, 2'b00}, 64'd0);
      chk("rst-mid wdata", 64'(wdata_o), 64'd0);
      chk("rst-mid wd", 64'(wd_o), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(3'd0, 32'd3, 32'd4, 1'b0, "mul-after-rst");

      for (int i = 0; i < 40; i++) begin
         logic [2:0]  rop;
         logic [31:0] ra, rb;
         int          mode;
         rop  = 3'($urandom_range(0, 7));
         ra   = $urandom;
         rb   = $urandom;
         mode = $urandom_range(0, 7);
         if (mode == 0) rb = 32'd0;
         else if (mode == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
         else if (mode == 2) begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 50); end
         else if (mode == 3) rb = 32'(-$urandom_range(1, 50));
         run_op(rop, ra, rb, 1'($urandom), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
